// File: rtl/multiplicador_algoritmico_if.sv
// Start/Done handshake bundle shared by the sequential multiplier and its controller.
`default_nettype none

interface multiplicador_algoritmico_if #(
   parameter int tamanyo = 32
) ();
   logic                   Start;
   logic [tamanyo-1:0]     A;
   logic [tamanyo-1:0]     B;
   logic [2*tamanyo-1:0]   Prod;
   logic                   Busy;
   logic                   Done;

   modport master (output Start, output A, output B, input Prod, input Busy, input Done);
   modport slave  (input Start, input A, input B, output Prod, output Busy, output Done);
endinterface

`default_nettype wire

// File: rtl/multiplicador_algoritmico.sv
// Sequential signed shift-and-add multiplier: multiplies operand magnitudes, then applies the sign.
`default_nettype none

module multiplicador_algoritmico #(
   parameter int tamanyo = 32
) (
   input  wire logic                   CLK,
   input  wire logic                   RSTa,
   multiplicador_algoritmico_if.slave  bus
);

   localparam int                    CW        = $clog2(tamanyo);
   localparam logic [CW-1:0]         CONT_INIT = CW'(tamanyo - 1);
   localparam logic [CW-1:0]         ONE_C     = 1;
   localparam logic [tamanyo-1:0]    ONE_N     = 1;
   localparam logic [2*tamanyo-1:0]  ONE_P     = 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADD   = 2'd1,
      S_SHIFT = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [tamanyo-1:0]     accu_q, accu_d;
   logic [tamanyo-1:0]     q_q, q_d;
   logic [tamanyo-1:0]     m_q, m_d;
   logic                   c_q, c_d;
   logic [CW-1:0]          cont_q, cont_d;
   logic                   sign_a_q, sign_a_d;
   logic                   sign_b_q, sign_b_d;
   logic [2*tamanyo-1:0]   prod_q, prod_d;
   logic                   done_q, done_d;
   logic                   busy_q, busy_d;

   logic [tamanyo:0]       sum;
   logic [2*tamanyo-1:0]   mag;

   assign sum = {1'b0, accu_q} + {1'b0, m_q};
   assign mag = {accu_q, q_q};

   always_comb begin
      state_d  = state_q;
      accu_d   = accu_q;
      q_d      = q_q;
      m_d      = m_q;
      c_d      = c_q;
      cont_d   = cont_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      prod_d   = prod_q;
      done_d   = done_q;
      busy_d   = busy_q;

      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               sign_a_d = bus.A[tamanyo-1];
               sign_b_d = bus.B[tamanyo-1];
               // The most-negative operand negates to 2^(tamanyo-1), which is exact as unsigned.
               m_d      = bus.A[tamanyo-1] ? (~bus.A + ONE_N) : bus.A;
               q_d      = bus.B[tamanyo-1] ? (~bus.B + ONE_N) : bus.B;
               accu_d   = '0;
               c_d      = 1'b0;
               cont_d   = CONT_INIT;
               done_d   = 1'b0;
               busy_d   = 1'b1;
               state_d  = S_ADD;
            end
         end
         S_ADD: begin
            if (q_q[0]) begin
               {c_d, accu_d} = sum;
            end
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            {c_d, accu_d, q_d} = {1'b0, c_q, accu_q, q_q[tamanyo-1:1]};
            cont_d  = cont_q - ONE_C;
            state_d = (cont_q != '0) ? S_ADD : S_FIN;
         end
         S_FIN: begin
            prod_d  = (sign_a_q ^ sign_b_q) ? (~mag + ONE_P) : mag;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         state_q  <= S_IDLE;
         accu_q   <= '0;
         q_q      <= '0;
         m_q      <= '0;
         c_q      <= 1'b0;
         cont_q   <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         prod_q   <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         accu_q   <= accu_d;
         q_q      <= q_d;
         m_q      <= m_d;
         c_q      <= c_d;
         cont_q   <= cont_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         prod_q   <= prod_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.Prod = prod_q;
   assign bus.Done = done_q;
   assign bus.Busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_multiplicador_algoritmico.sv
// Directed and random checks of the sequential multiplier at widths 8 and 32.
`default_nettype none

module tb_multiplicador_algoritmico;

   logic CLK;
   logic RSTa;

   multiplicador_algoritmico_if #(.tamanyo(8))  b8 ();
   multiplicador_algoritmico_if #(.tamanyo(32)) b32 ();

   multiplicador_algoritmico #(.tamanyo(8))  u_dut8  (.CLK(CLK), .RSTa(RSTa), .bus(b8.slave));
   multiplicador_algoritmico #(.tamanyo(32)) u_dut32 (.CLK(CLK), .RSTa(RSTa), .bus(b32.slave));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int   total = 0;
   int   bad   = 0;
   logic overlap = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge CLK) begin
      if ((b8.Done && b8.Busy) || (b32.Done && b32.Busy)) overlap = 1'b1;
   end

   // Pulse Start for one cycle, then wait (bounded) for Done; cyc counts edges after the accepting one.
   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] p, output int cyc, output int nb);
      @(negedge CLK);
      b8.A = a; b8.B = b; b8.Start = 1'b1;
      @(negedge CLK);
      b8.Start = 1'b0;
      cyc = 0; nb = 0;
      while (!b8.Done && cyc < 200) begin
         if (b8.Busy) nb++;
         @(negedge CLK);
         cyc++;
      end
      p = b8.Prod;
      chk("done8", {63'd0, b8.Done}, 64'd1);
   endtask

   task automatic op32(input logic [31:0] a, input logic [31:0] b, output logic [63:0] p);
      int cyc;
      @(negedge CLK);
      b32.A = a; b32.B = b; b32.Start = 1'b1;
      @(negedge CLK);
      b32.Start = 1'b0;
      cyc = 0;
      while (!b32.Done && cyc < 400) begin
         @(negedge CLK);
         cyc++;
      end
      p = b32.Prod;
      chk("done32", {63'd0, b32.Done}, 64'd1);
   endtask

   task automatic wait8();
      int cyc;
      cyc = 0;
      while (!b8.Done && cyc < 200) begin
         @(negedge CLK);
         cyc++;
      end
   endtask

   logic [7:0]  va [5] = '{8'h80, 8'h80, 8'h7F, 8'h00, 8'hFF};
   logic [7:0]  vb [5] = '{8'h80, 8'h7F, 8'h7F, 8'hFB, 8'hFF};
   logic [15:0] vp [5] = '{16'h4000, 16'hC080, 16'h3F01, 16'h0000, 16'h0001};

   logic [15:0] p16, e16;
   logic [63:0] p64, e64;
   logic [7:0]  ra, rb;
   logic [31:0] ra32, rb32;
   int          cyc, nb;

   initial begin
      RSTa = 1'b0;
      b8.Start = 1'b0;  b8.A = '0;  b8.B = '0;
      b32.Start = 1'b0; b32.A = '0; b32.B = '0;
      repeat (2) @(negedge CLK);
      chk("rst_prod", {48'd0, b8.Prod}, 64'd0);
      chk("rst_done", {63'd0, b8.Done}, 64'd0);
      chk("rst_busy", {63'd0, b8.Busy}, 64'd0);
      chk("rst_prod32", b32.Prod, 64'd0);
      RSTa = 1'b1;

      op8(8'd7, 8'hFD, p16, cyc, nb);
      chk("7x-3", {48'd0, p16}, 64'h0000_0000_0000_FFEB);
      chk("latency", 64'(cyc), 64'd17);
      chk("busy_cycles", 64'(nb), 64'd17);

      for (int i = 0; i < 5; i++) begin
         op8(va[i], vb[i], p16, cyc, nb);
         chk("vector", {48'd0, p16}, {48'd0, vp[i]});
      end

      // Back-to-back: Start stays high through the whole operation and across Done.
      @(negedge CLK);
      b8.A = 8'd3; b8.B = 8'd4; b8.Start = 1'b1;
      @(negedge CLK);
      wait8();
      chk("b2b_first", {48'd0, b8.Prod}, 64'h000C);
      b8.A = 8'd6; b8.B = 8'hFE;
      @(negedge CLK);
      chk("b2b_done_drop", {63'd0, b8.Done}, 64'd0);
      chk("b2b_busy", {63'd0, b8.Busy}, 64'd1);
      b8.Start = 1'b0;
      wait8();
      chk("b2b_second", {48'd0, b8.Prod}, 64'h0000_0000_0000_FFF4);

      // Operands change and Start pulses while the operation is in flight.
      @(negedge CLK);
      b8.A = 8'hF9; b8.B = 8'd9; b8.Start = 1'b1;
      @(negedge CLK);
      b8.Start = 1'b0;
      repeat (4) @(negedge CLK);
      b8.A = 8'd100; b8.B = 8'd100; b8.Start = 1'b1;
      @(negedge CLK);
      b8.Start = 1'b0;
      wait8();
      chk("midop_ignored", {48'd0, b8.Prod}, 64'h0000_0000_0000_FFC1);

      // Asynchronous reset between edges aborts the operation.
      @(negedge CLK);
      b8.A = 8'd12; b8.B = 8'd12; b8.Start = 1'b1;
      @(negedge CLK);
      b8.Start = 1'b0;
      repeat (5) @(negedge CLK);
      #2 RSTa = 1'b0;
      #1;
      chk("arst_prod", {48'd0, b8.Prod}, 64'd0);
      chk("arst_done", {63'd0, b8.Done}, 64'd0);
      chk("arst_busy", {63'd0, b8.Busy}, 64'd0);
      @(negedge CLK);
      RSTa = 1'b1;
      op8(8'd5, 8'd9, p16, cyc, nb);
      chk("5x9", {48'd0, p16}, 64'h002D);

      for (int i = 0; i < 500; i++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         e16 = 16'($signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb}));
         op8(ra, rb, p16, cyc, nb);
         chk("rand8", {48'd0, p16}, {48'd0, e16});
      end

      op32(32'h8000_0000, 32'h8000_0000, p64);
      chk("min32xmin32", p64, 64'h4000_0000_0000_0000);
      for (int i = 0; i < 500; i++) begin
         ra32 = $urandom; rb32 = $urandom;
         e64 = 64'($signed({{32{ra32[31]}}, ra32}) * $signed({{32{rb32[31]}}, rb32}));
         op32(ra32, rb32, p64);
         chk("rand32", p64, e64);
      end

      chk("done_busy_overlap", {63'd0, overlap}, 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
